pipeline_control: RTL

//   Applies stall/flush requests to the 5-stage pipeline registers. Takes the load-use/ECALL stall

---
 rtl/pipe_ctrl_pkg.sv | 23 ++
 rtl/pipeline_control_watchdog.sv | 25 ++
 rtl/pipeline_control.sv | 97 +++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types for pipeline control
//   state_t       : control FSM state {RUN, DRAIN, HALTED}
//   stage_ctrl_t  : per-stage control bundle consumed by the pipeline registers
//   CTL_*         : the control bundle for each action the controller can take
package pipe_ctrl_pkg;
   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;
   typedef struct packed {
      logic pc_write;
      logic if_id_write;
      logic if_id_flush;
      logic id_ex_flush;
      logic ex_mem_write;
      logic mem_wb_write;
   } stage_ctrl_t;
   // A stage with write=1 and flush=1 loads a bubble.
   localparam stage_ctrl_t CTL_FREEZE     = 6'b000000;
   localparam stage_ctrl_t CTL_DRAIN      = 6'b011111;
   localparam stage_ctrl_t CTL_DRAIN_BUSY = 6'b011100;
   localparam stage_ctrl_t CTL_REDIRECT   = 6'b111111;
   localparam stage_ctrl_t CTL_HAZARD     = 6'b000111;
   localparam stage_ctrl_t CTL_IMEM       = 6'b011011;
   localparam stage_ctrl_t CTL_NORMAL     = 6'b110011;
endpackage

// File: rtl/pipeline_control_watchdog.sv
// pipe_watchdog: counts consecutive dmem busy cycles, sets a sticky timeout flag
//   clk     in  clock, rising edge
//   reset_n in  asynchronous active-low reset
//   busy    in  dmem access not complete this cycle
//   timeout out sticky: busy held for 2**W-1 consecutive cycles
module pipe_watchdog #(
   parameter int W = 8
) (
   input  logic clk,
   input  logic reset_n,
   input  logic busy,
   output logic timeout
);
   logic [W-1:0] cnt;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt     <= '0;
         timeout <= 1'b0;
      end else begin
         cnt     <= !busy ? '0 : (&cnt ? cnt : cnt + W'(1));
         // flag rises together with the count reaching all-ones
         timeout <= timeout | (busy && cnt == ~W'(1));
      end
   end
endmodule

// File: rtl/pipeline_control.sv
// pipeline_control: stall/flush/halt control for the 5-stage pipeline
//   Optional feature macro: PIPE_PERF_EN (perf counters; tied to 0 when undefined)
//   clk, reset_n        clock (rising) / asynchronous active-low reset
//   hazard_stall        load-use / ECALL stall from ID
//   branch_mispredict   EX redirect; IF/ID and ID/EX hold wrong-path instrs
//   halt_req            halting ECALL in EX
//   imem_busy           fetch not complete this cycle
//   dmem_busy           data access in MEM not complete this cycle
//   pc_write .. mem_wb_write  PC / stage load enables and bubble inserts
//   halted              sticky: pipeline drained after halt
//   mem_timeout         sticky: dmem watchdog expired
//   stall_cycles        cycles with pc_write=0 while RUN
//   flush_count         cycles with a mispredict applied
module pipeline_control
   import pipe_ctrl_pkg::*;
#(
   parameter int DRAIN_CYCLES = 2,
   parameter int TIMEOUT_W    = 8,
   parameter int CNT_W        = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             hazard_stall,
   input  logic             branch_mispredict,
   input  logic             halt_req,
   input  logic             imem_busy,
   input  logic             dmem_busy,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             halted,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_count
);
   localparam int DW = $clog2(DRAIN_CYCLES + 1);
   state_t      state;
   logic [DW-1:0] cnt;
   stage_ctrl_t ctl;
   logic        run, redirect;
   assign run      = state == RUN;
   assign redirect = run && !dmem_busy && !halt_req && branch_mispredict;
   always_comb begin
      ctl = CTL_FREEZE;
      if (run)
         ctl = dmem_busy         ? CTL_FREEZE   :
               halt_req          ? CTL_DRAIN    :
               branch_mispredict ? CTL_REDIRECT :
               hazard_stall      ? CTL_HAZARD   :
               imem_busy         ? CTL_IMEM     : CTL_NORMAL;
      else if (state == DRAIN)
         ctl = dmem_busy ? CTL_DRAIN_BUSY : CTL_DRAIN;
   end
   assign {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_mem_write, mem_wb_write} = ctl;
   assign halted = state == HALTED;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         case (state)
            RUN: if (!dmem_busy && halt_req) begin
               state <= DRAIN;
               cnt   <= DW'(DRAIN_CYCLES);
            end
            DRAIN: if (!dmem_busy) begin
               cnt <= cnt - DW'(1);
               if (cnt == DW'(1)) state <= HALTED;
            end
            default: ;
         endcase
      end
   end
   pipe_watchdog #(.W(TIMEOUT_W)) u_watchdog (
      .clk     (clk),
      .reset_n (reset_n),
      .busy    (dmem_busy),
      .timeout (mem_timeout)
   );
`ifdef PIPE_PERF_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stall_cycles <= '0;
         flush_count  <= '0;
      end else begin
         if (run && !pc_write && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
         if (redirect && !(&flush_count)) flush_count <= flush_count + CNT_W'(1);
      end
   end
`else
   assign stall_cycles = '0;
   assign flush_count  = '0;
`endif
endmodule
